// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns,
// FSM state encoding, decoder result type and digit-strobe helpers.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   typedef struct packed {
      logic       err;
      logic [3:0] value;
   } bcd_t;

   // True when exactly one digit strobe is active (low).
   function automatic logic sel_one_low(input logic [3:0] sel);
      logic r;
      case (sel)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] sel_index(input logic [3:0] sel);
      logic [1:0] r;
      case (sel)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment (active-low) to BCD lookup; blank maps to
// BLANK_CODE, anything outside the table is flagged as an error.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output bcd_t       dec
);

   // Fixed pattern lookup
   always_comb begin
      dec.err   = 1'b0;
      dec.value = BLANK_CODE;
      case (seg)
         SEG_0:     dec.value = 4'd0;
         SEG_1:     dec.value = 4'd1;
         SEG_2:     dec.value = 4'd2;
         SEG_3:     dec.value = 4'd3;
         SEG_4:     dec.value = 4'd4;
         SEG_5:     dec.value = 4'd5;
         SEG_6:     dec.value = 4'd6;
         SEG_7:     dec.value = 4'd7;
         SEG_8:     dec.value = 4'd8;
         SEG_9:     dec.value = 4'd9;
         SEG_BLANK: dec.value = BLANK_CODE;
         default:   dec.err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed seven-segment display: each strobed digit must hold
// a steady pattern for STABLE_CYCLES samples before it is decoded and stored.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg,
   input  logic [3:0]  dig_sel,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  digit_err,
   output logic        upd
);

   localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

   logic [6:0]  smp_seg, prev_seg;
   logic [3:0]  smp_sel, prev_sel;
   logic [1:0]  state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        same, capture;
   logic [1:0]  idx;
   bcd_t        dec;
   logic [15:0] digits_nx;
   logic [3:0]  valid_nx, err_nx;
   logic        chg, chg_nx;

   seg7_to_bcd u_dec (
      .seg (smp_seg),
      .dec (dec)
   );

   // Input sample stage plus one-deep history for the stability compare
   always_ff @(posedge clk) begin
      if (reset) begin
         smp_seg  <= 7'h7F;
         smp_sel  <= 4'hF;
         prev_seg <= 7'h7F;
         prev_sel <= 4'hF;
      end else begin
         smp_seg  <= seg;
         smp_sel  <= dig_sel;
         prev_seg <= smp_seg;
         prev_sel <= smp_sel;
      end
   end

   assign same = (smp_seg == prev_seg) && (smp_sel == prev_sel);
   assign idx  = sel_index(smp_sel);

   // Stability FSM: an invalid strobe always returns to IDLE
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      if (!sel_one_low(smp_sel)) begin
         state_nx = ST_IDLE;
         cnt_nx   = 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx = ST_SETTLE;
               cnt_nx   = 8'd1;
            end
            ST_SETTLE: begin
               if (!same) begin
                  cnt_nx = 8'd1;
               end else if (cnt + 8'd1 >= STABLE) begin
                  cnt_nx   = STABLE;
                  capture  = 1'b1;
                  state_nx = ST_HOLD;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
            ST_HOLD: begin
               if (!same) begin
                  state_nx = ST_SETTLE;
                  cnt_nx   = 8'd1;
               end else begin
                  state_nx = ST_HOLD;
               end
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = 8'd0;
            end
         endcase
      end
   end

   // Capture update; chg flags a visible change so upd can follow a cycle later
   always_comb begin
      digits_nx = digits;
      valid_nx  = valid;
      err_nx    = digit_err;
      chg_nx    = 1'b0;
      if (capture) begin
         if (dec.err) begin
            err_nx[idx] = 1'b1;
            chg_nx      = ~digit_err[idx];
         end else begin
            digits_nx[{idx, 2'b00} +: 4] = dec.value;
            valid_nx[idx] = 1'b1;
            err_nx[idx]   = 1'b0;
            chg_nx        = (digits[{idx, 2'b00} +: 4] != dec.value) || digit_err[idx];
         end
      end else begin
         chg_nx = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         digits    <= 16'hFFFF;
         valid     <= 4'h0;
         digit_err <= 4'h0;
         chg       <= 1'b0;
         upd       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         digits    <= digits_nx;
         valid     <= valid_nx;
         digit_err <= err_nx;
         chg       <= chg_nx;
         upd       <= chg;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios, a decode table and
// randomized traffic compared each cycle against a run-length reference model.
module tb_seg7_capture;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic [15:0] digits;
   logic [3:0]  valid;
   logic [3:0]  digit_err;
   logic        upd;

   int n_pass  = 0;
   int n_total = 0;

   logic [6:0] pat [0:9];

   // Reference model: capture happens when a valid strobe has produced exactly
   // SC identical consecutive samples; results appear one cycle later, upd two.
   logic [15:0] m_dig;
   logic [3:0]  m_val, m_err;
   logic        c1, c2;
   logic [6:0]  m_seg;
   logic [3:0]  m_sel;
   int          m_run;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] sel;
      logic [3:0] nib;
      logic       err;
   } vec_t;
   vec_t tbl [0:13];

   seg7_capture #(.STABLE_CYCLES(SC)) dut (
      .clk       (clk),
      .reset     (reset),
      .seg       (seg),
      .dig_sel   (dig_sel),
      .digits    (digits),
      .valid     (valid),
      .digit_err (digit_err),
      .upd       (upd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_dig = 16'hFFFF;
      m_val = 4'h0;
      m_err = 4'h0;
      c1 = 1'b0;
      c2 = 1'b0;
      m_seg = 7'h7F;
      m_sel = 4'hF;
      m_run = 0;
   endtask

   task automatic model_step(input logic [6:0] s, input logic [3:0] d);
      int n;
      int code;
      logic chg;
      chg = 1'b0;
      if ($countones(~d) != 1) m_run = 0;
      else if (m_run > 0 && s == m_seg && d == m_sel) m_run++;
      else m_run = 1;
      m_seg = s;
      m_sel = d;
      if (m_run == SC) begin
         n = 0;
         for (int i = 0; i < 4; i++) if (!d[i]) n = i;
         code = -1;
         for (int i = 0; i < 10; i++) if (pat[i] == s) code = i;
         if (s == 7'h7F) code = 15;
         if (code < 0) begin
            chg = !m_err[n];
            m_err[n] = 1'b1;
         end else begin
            chg = (m_dig[4*n +: 4] != code[3:0]) || m_err[n];
            m_dig[4*n +: 4] = code[3:0];
            m_val[n] = 1'b1;
            m_err[n] = 1'b0;
         end
      end
      c2 = c1;
      c1 = chg;
   endtask

   task automatic cycle(input logic [6:0] s, input logic [3:0] d);
      seg = s;
      dig_sel = d;
      @(posedge clk);
      #1;
      chk("cyc_digits", 32'(digits), 32'(m_dig));
      chk("cyc_valid", 32'(valid), 32'(m_val));
      chk("cyc_err", 32'(digit_err), 32'(m_err));
      chk("cyc_upd", 32'(upd), 32'(c2));
      model_step(s, d);
   endtask

   task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n, output int ups);
      ups = 0;
      for (int i = 0; i < n; i++) begin
         cycle(s, d);
         ups += int'(upd);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_digits", 32'(digits), 32'h0000FFFF);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_err", 32'(digit_err), 32'h0);
      chk("rst_upd", 32'(upd), 32'h0);
      seg = 7'h7F;
      dig_sel = 4'hF;
      @(posedge clk);
      #1;
      chk("rst_upd2", 32'(upd), 32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int u;
      int r;
      int n;
      logic [6:0] s;
      logic [3:0] d;
      logic [3:0] sels [0:5];

      pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
      pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
      pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
      pat[9] = 7'b0000100;
      sels[0] = 4'b1110; sels[1] = 4'b1101; sels[2] = 4'b1011;
      sels[3] = 4'b0111; sels[4] = 4'b1111; sels[5] = 4'b1001;

      reset = 1'b1;
      seg = 7'h7F;
      dig_sel = 4'hF;
      model_reset();
      do_reset();

      // Digit 0 shows 2: capture lands on the fifth edge, upd one edge later
      hold(7'b0010010, 4'b1110, 4, u);
      chk("s1_pre_digits", 32'(digits), 32'h0000FFFF);
      hold(7'b0010010, 4'b1110, 1, u);
      chk("s1_digits", 32'(digits), 32'h0000FFF2);
      chk("s1_valid", 32'(valid), 32'h1);
      chk("s1_upd_early", 32'(upd), 32'h0);
      hold(7'b0010010, 4'b1110, 1, u);
      chk("s1_upd", 32'(upd), 32'h1);
      hold(7'b0010010, 4'b1110, 2, u);
      chk("s1_single_pulse", 32'(u), 32'h0);

      // Toggling faster than the stability window never captures
      do_reset();
      for (int k = 0; k < 10; k++) begin
         hold(7'b0000110, 4'b1110, 2, u);
         hold(7'b1001111, 4'b1110, 2, u);
      end
      chk("s2_digits", 32'(digits), 32'h0000FFFF);
      chk("s2_valid", 32'(valid), 32'h0);

      // Invalid strobes leave a captured display untouched
      hold(7'b0000000, 4'b1011, 6, u);
      hold(7'b0000000, 4'b1100, 6, u);
      chk("s3_upd_multi", 32'(u), 32'h0);
      hold(7'b0000000, 4'b1111, 6, u);
      chk("s3_upd_none", 32'(u), 32'h0);
      chk("s3_digits", 32'(digits), 32'h0000F8FF);

      // Digit 3: undecodable pattern keeps the old nibble, then recovers
      hold(7'b0000110, 4'b0111, 6, u);
      hold(7'b1111110, 4'b0111, 6, u);
      chk("s4_err", 32'(digit_err), 32'h8);
      chk("s4_keep", 32'(digits[15:12]), 32'h3);
      chk("s4_valid", 32'(valid[3]), 32'h1);
      hold(7'b0000100, 4'b0111, 6, u);
      chk("s4_nine", 32'(digits[15:12]), 32'h9);
      chk("s4_err_clr", 32'(digit_err), 32'h0);

      // Digit 1: repeated identical value is silent, blank is a real change
      hold(7'b0100100, 4'b1101, 6, u);
      chk("s5_first_upd", 32'(u), 32'h1);
      hold(7'h7F, 4'hF, 2, u);
      hold(7'b0100100, 4'b1101, 7, u);
      chk("s5_repeat_upd", 32'(u), 32'h0);
      chk("s5_five", 32'(digits[7:4]), 32'h5);
      hold(7'h7F, 4'b1101, 7, u);
      chk("s5_blank", 32'(digits[7:4]), 32'hF);
      chk("s5_blank_upd", 32'(u), 32'h1);

      // Reset two cycles into SETTLE aborts the capture
      hold(7'b0001111, 4'b1110, 3, u);
      do_reset();

      // Decode table across all digit positions
      tbl[0]  = '{7'b0000001, 4'b1110, 4'h0, 1'b0};
      tbl[1]  = '{7'b1001111, 4'b1101, 4'h1, 1'b0};
      tbl[2]  = '{7'b0010010, 4'b1011, 4'h2, 1'b0};
      tbl[3]  = '{7'b0000110, 4'b0111, 4'h3, 1'b0};
      tbl[4]  = '{7'b1001100, 4'b1110, 4'h4, 1'b0};
      tbl[5]  = '{7'b0100100, 4'b1101, 4'h5, 1'b0};
      tbl[6]  = '{7'b0100000, 4'b1011, 4'h6, 1'b0};
      tbl[7]  = '{7'b0001111, 4'b0111, 4'h7, 1'b0};
      tbl[8]  = '{7'b0000000, 4'b1110, 4'h8, 1'b0};
      tbl[9]  = '{7'b0000100, 4'b1101, 4'h9, 1'b0};
      tbl[10] = '{7'b1111111, 4'b1011, 4'hF, 1'b0};
      tbl[11] = '{7'b1111110, 4'b0111, 4'h7, 1'b1};
      tbl[12] = '{7'b0110000, 4'b1110, 4'h8, 1'b1};
      tbl[13] = '{7'b0000001, 4'b0111, 4'h0, 1'b0};
      for (int v = 0; v < 14; v++) begin
         hold(tbl[v].seg, tbl[v].sel, SC + 2, u);
         n = 0;
         for (int i = 0; i < 4; i++) if (!tbl[v].sel[i]) n = i;
         chk("tbl_nibble", 32'(digits[4*n +: 4]), 32'(tbl[v].nib));
         chk("tbl_err", 32'(digit_err[n]), 32'(tbl[v].err));
         hold(7'h7F, 4'hF, 1, u);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 100; k++) begin
         r = int'($urandom_range(0, 13));
         if (r < 10) s = pat[r];
         else if (r == 10) s = 7'h7F;
         else s = 7'($urandom);
         d = sels[$urandom_range(0, 5)];
         if ($urandom_range(0, 39) == 0) do_reset();
         hold(s, d, int'($urandom_range(1, 7)), u);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL be the number of consecutive identical input samples required before a capture (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 seg  input  7  SHALL carry active-low segments, bit6=a down to bit0=g.
REQ-005 dig_sel  input  4  SHALL carry the active-low digit strobe; bit n low means digit n is driven.
REQ-006 digits  output  16  SHALL hold the captured BCD values; digit n occupies bits [4n+3:4n].
REQ-007 valid  output  4  SHALL set bit n once digit n has been captured at least once.
REQ-008 digit_err  output  4  SHALL set bit n when the last stable pattern on digit n was not decodable.
REQ-009 upd  output  1  SHALL pulse for one cycle when any digits nibble or digit_err bit changes.

Function
REQ-010 Decode table (seg -> value) SHALL be fixed:
- 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
- 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
- 1111111 (blank) -> 4'hF, not an error
REQ-011 Any other pattern SHALL set digit_err[n], leave digits nibble n unchanged and leave valid[n] unchanged.
REQ-012 Inputs SHALL be registered once (sample stage) before any comparison, giving a 1-cycle input latency.
REQ-013 FSM states SHALL be IDLE, SETTLE and HOLD.
REQ-014 IDLE -> SETTLE SHALL occur when the sampled dig_sel has exactly one low bit; the stability counter loads 1.
REQ-015 In SETTLE, a sample identical to the previous {seg,dig_sel} SHALL increment the counter; any difference SHALL reload the counter to 1 and stay in SETTLE.
REQ-016 When the counter reaches STABLE_CYCLES, the FSM SHALL perform the capture (decode, update digits/valid/digit_err) in that same cycle and enter HOLD.
REQ-017 In HOLD, no further capture SHALL occur until the sampled {seg,dig_sel} changes; a change SHALL go to SETTLE (counter=1) or to IDLE per REQ-018.
REQ-018 A sampled dig_sel that is all-high or has more than one low bit SHALL force IDLE from any state, with no capture.
REQ-019 Latency SHALL be STABLE_CYCLES+1 cycles from the first stable input edge to outputs updating; upd SHALL assert in the cycle after the outputs change.
REQ-020 A capture that reproduces the stored nibble and error bit SHALL set valid[n] if clear but SHALL NOT pulse upd.
REQ-021 The counter SHALL saturate at STABLE_CYCLES and SHALL never wrap.

Reset
REQ-022 While reset is high at a clock edge, the following SHALL be cleared: FSM=IDLE, counter=0, sample registers=all-ones (blank, no digit).
REQ-023 The same reset SHALL set digits=16'hFFFF, valid=0, digit_err=0, upd=0.
REQ-024 Reset asserted mid-SETTLE SHALL abort the capture with no output change other than the REQ-023 values.

Structure
REQ-025 Package seg7_pkg SHALL hold the ten digit patterns, the BLANK pattern, the BLANK_CODE (4'hF) constant and the FSM state encoding.
REQ-026 The combinational sub-module seg7_to_bcd (seg -> {err,value}) SHALL implement REQ-010/011 and SHALL be instantiated once.

Verification
REQ-027 Directed scenarios:
- Reset, then seg=0010010, dig_sel=1110 held 6 cycles -> digits[3:0]=2, valid=0001, one upd pulse, capture at cycle 5.
- seg toggles every 2 cycles with STABLE_CYCLES=4 -> no capture, digits stay 16'hFFFF.
- dig_sel=1100 or 1111 with seg=0000000 -> stays IDLE, no upd, outputs unchanged.
- Digit 3: stable 1111110 -> digit_err=1000, digits[15:12] keeps its prior value; then stable 0000100 -> digits[15:12]=9, digit_err=0000.
- Re-present stored value 5 on digit 1 -> no upd; blank 1111111 -> nibble=F, upd pulses.
- Assert reset at cycle 2 of SETTLE -> all outputs at reset values next cycle, no upd.
